// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller:
// forward-source codes, the NOP encoding and the per-stage shadow record.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam logic [15:0] NOP_INSTR = 16'b0000010000110000;

    // Shadow dst is sized for the widest supported register index; narrower indices are zero-extended.
    localparam int REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_AW_MAX-1:0] dst;
    } stage_shadow_t;

    localparam stage_shadow_t SHADOW_NONE = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        dst:       {REG_AW_MAX{1'b0}}
    };

    function automatic logic producer_hit(input stage_shadow_t s,
                                          input logic [REG_AW_MAX-1:0] idx,
                                          input logic used);
        return s.valid & s.reg_write & used & (s.dst == idx);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_mux.sv
// Per-operand forwarding selector: picks the youngest in-flight producer of
// the operand register and flags when the decode instruction must wait.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int W      = 16,
    parameter int N      = 3,
    parameter int FWD_EN = 1
) (
    input  logic [N-1:0]  idx_i,
    input  logic          used_i,
    input  stage_shadow_t ex_s_i,
    input  stage_shadow_t mem_s_i,
    input  stage_shadow_t wb_s_i,
    input  logic [W-1:0]  rf_data_i,
    input  logic [W-1:0]  ex_data_i,
    input  logic [W-1:0]  mem_data_i,
    input  logic [W-1:0]  wb_data_i,
    output logic [1:0]    sel_o,
    output logic [W-1:0]  data_o,
    output logic          load_use_o
);

    logic [REG_AW_MAX-1:0] idx_ext_s;
    logic                  hit_ex_s;
    logic                  hit_mem_s;
    logic                  hit_wb_s;
    logic                  ld_flags_unused_s;

    assign idx_ext_s = REG_AW_MAX'(idx_i);
    assign hit_ex_s  = producer_hit(ex_s_i, idx_ext_s, used_i);
    assign hit_mem_s = producer_hit(mem_s_i, idx_ext_s, used_i);
    assign hit_wb_s  = producer_hit(wb_s_i, idx_ext_s, used_i);

    // Older-stage load flags do not steer selection here; the M-stage data is pre-resolved by the top.
    assign ld_flags_unused_s = mem_s_i.mem_read ^ wb_s_i.mem_read;

    // Youngest matching producer wins; only an E-stage load forces a wait when forwarding is on.
    always_comb begin
        sel_o      = FWD_RF;
        data_o     = rf_data_i;
        load_use_o = 1'b0;
        if (FWD_EN == 0) begin
            load_use_o = hit_ex_s | hit_mem_s | hit_wb_s;
        end else if (hit_ex_s) begin
            sel_o      = FWD_EX;
            data_o     = ex_data_i;
            load_use_o = ex_s_i.mem_read;
        end else if (hit_mem_s) begin
            sel_o  = FWD_MEM;
            data_o = mem_data_i;
        end else if (hit_wb_s) begin
            sel_o  = FWD_WB;
            data_o = wb_data_i;
        end else begin
            sel_o  = FWD_RF;
            data_o = rf_data_i;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside decode: shadows E/M/W, forwards operands,
// stalls on load-use (or any RAW when forwarding is off) and stretches F/D flushes.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int W            = 16,
    parameter int N            = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int FWD_EN       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic [N-1:0] id_src,
    input  logic [N-1:0] id_dst,
    input  logic         id_src_used,
    input  logic         id_dst_used,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         redirect,
    input  logic [W-1:0] id_rsrc,
    input  logic [W-1:0] id_rdst,
    input  logic [W-1:0] ex_alu_out,
    input  logic [W-1:0] mem_rd,
    input  logic [W-1:0] wb_wd,
    output logic [W-1:0] opa,
    output logic [W-1:0] opb,
    output logic [1:0]   fwd_sel_a,
    output logic [1:0]   fwd_sel_b,
    output logic         stall_fd,
    output logic         bubble_de,
    output logic         flush_fd,
    output logic         ex_valid,
    output logic         mem_valid,
    output logic         wb_valid
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    stage_shadow_t ex_q;
    stage_shadow_t ex_d;
    stage_shadow_t mem_q;
    stage_shadow_t wb_q;
    logic [2:0]    flush_cnt_q;
    logic [2:0]    flush_cnt_d;
    logic [W-1:0]  alu_dly_q;
    logic [W-1:0]  mem_src_s;
    logic          hold_a_s;
    logic          hold_b_s;
    logic          redirect_ok_s;

    // A non-load in M delivers last cycle's ALU result; a load delivers the memory read data.
    assign mem_src_s = mem_q.mem_read ? mem_rd : alu_dly_q;

    fwd_mux #(.W(W), .N(N), .FWD_EN(FWD_EN)) u_fwd_a (
        .idx_i      (id_src),
        .used_i     (id_src_used & id_valid),
        .ex_s_i     (ex_q),
        .mem_s_i    (mem_q),
        .wb_s_i     (wb_q),
        .rf_data_i  (id_rsrc),
        .ex_data_i  (ex_alu_out),
        .mem_data_i (mem_src_s),
        .wb_data_i  (wb_wd),
        .sel_o      (fwd_sel_a),
        .data_o     (opa),
        .load_use_o (hold_a_s)
    );

    fwd_mux #(.W(W), .N(N), .FWD_EN(FWD_EN)) u_fwd_b (
        .idx_i      (id_dst),
        .used_i     (id_dst_used & id_valid),
        .ex_s_i     (ex_q),
        .mem_s_i    (mem_q),
        .wb_s_i     (wb_q),
        .rf_data_i  (id_rdst),
        .ex_data_i  (ex_alu_out),
        .mem_data_i (mem_src_s),
        .wb_data_i  (wb_wd),
        .sel_o      (fwd_sel_b),
        .data_o     (opb),
        .load_use_o (hold_b_s)
    );

    // A slot being flushed is wrong-path, so its hazards never hold the F/D buffer.
    assign flush_fd      = (flush_cnt_q != 3'd0);
    assign stall_fd      = (hold_a_s | hold_b_s) & ~flush_fd;
    assign bubble_de     = stall_fd;
    assign redirect_ok_s = redirect & id_valid & ~stall_fd;

    assign ex_valid  = ex_q.valid;
    assign mem_valid = mem_q.valid;
    assign wb_valid  = wb_q.valid;

    // Next E shadow and flush-counter reload/decrement.
    always_comb begin
        ex_d        = SHADOW_NONE;
        flush_cnt_d = flush_cnt_q;
        if (!(bubble_de | flush_fd | ~id_valid)) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.dst       = REG_AW_MAX'(id_dst);
        end else begin
            ex_d = SHADOW_NONE;
        end
        if (redirect_ok_s) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_fd) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Shadow pipeline, flush counter and delayed ALU result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= SHADOW_NONE;
            mem_q       <= SHADOW_NONE;
            wb_q        <= SHADOW_NONE;
            flush_cnt_q <= 3'd0;
            alu_dly_q   <= {W{1'b0}};
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            flush_cnt_q <= flush_cnt_d;
            alu_dly_q   <= ex_alu_out;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, forwarding on):
// directed scenarios plus randomized traffic against an in-flight instruction model.
module tb_pipe_hazard_ctrl;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int FC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, id_valid, id_src_used, id_dst_used, id_reg_write, id_mem_read, redirect;
    logic [N-1:0] id_src, id_dst;
    logic [W-1:0] id_rsrc, id_rdst, ex_alu_out, mem_rd, wb_wd;
    logic [W-1:0] opa, opb;
    logic [1:0]   fwd_sel_a, fwd_sel_b;
    logic         stall_fd, bubble_de, flush_fd, ex_valid, mem_valid, wb_valid;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.W(W), .N(N), .FLUSH_CYCLES(FC), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_dst(id_dst),
        .id_src_used(id_src_used), .id_dst_used(id_dst_used), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .redirect(redirect), .id_rsrc(id_rsrc), .id_rdst(id_rdst),
        .ex_alu_out(ex_alu_out), .mem_rd(mem_rd), .wb_wd(wb_wd), .opa(opa), .opb(opb),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_fd(stall_fd), .bubble_de(bubble_de),
        .flush_fd(flush_fd), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid)
    );

    // Reference model: the instructions in flight in E(0), M(1), W(2).
    typedef struct { bit v; bit rw; bit ld; int dst; } instr_t;
    instr_t       stg [3];
    logic [W-1:0] prev_alu;
    int           flush_left;

    logic [W-1:0] e_opa, e_opb;
    int           e_sel_a, e_sel_b;
    bit           e_stall, e_flush;

    function automatic void resolve(input int idx, input bit used, input logic [W-1:0] rf,
                                    output int sel, output logic [W-1:0] data, output bit hold);
        int first;
        first = -1;
        sel   = 0;
        data  = rf;
        hold  = 1'b0;
        if (used && id_valid)
            for (int s = 2; s >= 0; s--)
                if (stg[s].v && stg[s].rw && stg[s].dst == idx) first = s;
        if (first == 0) begin
            sel = 1; data = ex_alu_out; hold = stg[0].ld;
        end else if (first == 1) begin
            sel = 2; data = stg[1].ld ? mem_rd : prev_alu;
        end else if (first == 2) begin
            sel = 3; data = wb_wd;
        end
    endfunction

    function automatic void model_eval();
        bit ha, hb;
        resolve(int'(id_src), id_src_used, id_rsrc, e_sel_a, e_opa, ha);
        resolve(int'(id_dst), id_dst_used, id_rdst, e_sel_b, e_opb, hb);
        e_flush = (flush_left > 0);
        e_stall = (ha || hb) && !e_flush;
    endfunction

    function automatic void model_advance();
        bit accept;
        if (rst) begin
            for (int s = 0; s < 3; s++) stg[s] = '{v: 1'b0, rw: 1'b0, ld: 1'b0, dst: 0};
            flush_left = 0;
            prev_alu   = '0;
        end else begin
            accept = redirect && id_valid && !e_stall;
            stg[2] = stg[1];
            stg[1] = stg[0];
            if (e_stall || e_flush || !id_valid) stg[0] = '{v: 1'b0, rw: 1'b0, ld: 1'b0, dst: 0};
            else stg[0] = '{v: 1'b1, rw: id_reg_write, ld: id_mem_read, dst: int'(id_dst)};
            if (accept) flush_left = FC;
            else if (flush_left > 0) flush_left--;
            prev_alu = ex_alu_out;
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic set_dec(input bit v, input int src, input int dst, input bit su, input bit du,
                           input bit rw, input bit ld, input bit rd);
        id_valid = v; id_src = N'(src); id_dst = N'(dst); id_src_used = su; id_dst_used = du;
        id_reg_write = rw; id_mem_read = ld; redirect = rd;
    endtask

    task automatic drain();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        settle();
        checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush_fd); end
        checks++; if (stall_fd !== 1'b0 || bubble_de !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b%b exp=00", stall_fd, bubble_de); end
        checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin errors++; $display("FAIL reset_valids got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
    endtask

    task automatic test_ex_forward();
        set_dec(1, 0, 1, 0, 0, 1, 0, 0);
        tick();
        set_dec(1, 1, 4, 1, 0, 0, 0, 0);
        ex_alu_out = 16'h00A5; id_rsrc = 16'h5555;
        settle();
        checks++; if (fwd_sel_a !== 2'd1) begin errors++; $display("FAIL ex_fwd_sel got=%0d exp=1", fwd_sel_a); end
        checks++; if (opa !== 16'h00A5) begin errors++; $display("FAIL ex_fwd_opa got=%h exp=00a5", opa); end
        checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL ex_fwd_stall got=%b exp=0", stall_fd); end
        tick();
        drain();
    endtask

    task automatic test_load_use();
        set_dec(1, 0, 2, 0, 0, 1, 1, 0);
        tick();
        set_dec(1, 5, 2, 0, 1, 0, 0, 0);
        id_rdst = 16'hBEEF;
        settle();
        checks++; if (stall_fd !== 1'b1 || bubble_de !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b%b exp=11", stall_fd, bubble_de); end
        tick();
        mem_rd = 16'h1234;
        settle();
        checks++; if (fwd_sel_b !== 2'd2) begin errors++; $display("FAIL lu_sel_b got=%0d exp=2", fwd_sel_b); end
        checks++; if (opb !== 16'h1234) begin errors++; $display("FAIL lu_opb got=%h exp=1234", opb); end
        checks++; if (stall_fd !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL lu_resolved stall=%b ex_valid=%b exp=0,0", stall_fd, ex_valid); end
        tick();
        drain();
    endtask

    task automatic test_priority();
        set_dec(1, 0, 3, 0, 0, 1, 0, 0);
        tick();
        set_dec(1, 0, 6, 0, 0, 0, 0, 0);
        tick();
        set_dec(1, 0, 3, 0, 0, 1, 0, 0);
        tick();
        set_dec(1, 3, 0, 1, 0, 0, 0, 0);
        ex_alu_out = 16'h0E0E; wb_wd = 16'h0B0B; id_rsrc = 16'h0F0F;
        settle();
        checks++; if (fwd_sel_a !== 2'd1) begin errors++; $display("FAIL prio_sel got=%0d exp=1", fwd_sel_a); end
        checks++; if (opa !== 16'h0E0E) begin errors++; $display("FAIL prio_opa got=%h exp=0e0e", opa); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL prio_wb_valid got=%b exp=1", wb_valid); end
        tick();
        drain();
    endtask

    task automatic test_flush();
        set_dec(1, 0, 0, 0, 0, 0, 0, 1);
        settle();
        checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL fl_c0 got=%b exp=0", flush_fd); end
        tick();
        set_dec(1, 0, 7, 0, 0, 1, 0, 0);
        settle();
        checks++; if (flush_fd !== 1'b1 || ex_valid !== 1'b1) begin errors++; $display("FAIL fl_c1 flush=%b ex_valid=%b exp=1,1", flush_fd, ex_valid); end
        tick();
        settle();
        checks++; if (flush_fd !== 1'b1 || ex_valid !== 1'b0) begin errors++; $display("FAIL fl_c2 flush=%b ex_valid=%b exp=1,0", flush_fd, ex_valid); end
        tick();
        set_dec(1, 0, 5, 0, 0, 1, 0, 0);
        settle();
        checks++; if (flush_fd !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL fl_c3 flush=%b ex_valid=%b exp=0,0", flush_fd, ex_valid); end
        tick();
        settle();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL fl_c4 ex_valid got=%b exp=1", ex_valid); end
        drain();
    endtask

    task automatic test_redirect_stall();
        set_dec(1, 0, 4, 0, 0, 1, 1, 0);
        tick();
        set_dec(1, 4, 0, 1, 0, 0, 0, 1);
        settle();
        checks++; if (stall_fd !== 1'b1 || flush_fd !== 1'b0) begin errors++; $display("FAIL rs_c0 stall=%b flush=%b exp=1,0", stall_fd, flush_fd); end
        tick();
        settle();
        checks++; if (stall_fd !== 1'b0 || flush_fd !== 1'b0) begin errors++; $display("FAIL rs_c1 stall=%b flush=%b exp=0,0", stall_fd, flush_fd); end
        tick();
        set_dec(1, 0, 1, 0, 0, 0, 0, 0);
        settle();
        checks++; if (flush_fd !== 1'b1) begin errors++; $display("FAIL rs_c2 flush got=%b exp=1", flush_fd); end
        drain();
    endtask

    task automatic test_reset_mid();
        set_dec(1, 0, 0, 0, 0, 1, 0, 1);
        tick();
        set_dec(1, 0, 2, 0, 0, 1, 0, 0);
        tick();
        rst = 1'b1;
        settle();
        checks++; if (flush_fd !== 1'b1) begin errors++; $display("FAIL rm_flush_pre got=%b exp=1", flush_fd); end
        tick();
        rst = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (flush_fd !== 1'b0 || {ex_valid, mem_valid, wb_valid} !== 3'b000) begin errors++; $display("FAIL rm_flush_post flush=%b valids=%b exp=0,000", flush_fd, {ex_valid, mem_valid, wb_valid}); end
        set_dec(1, 0, 2, 0, 0, 1, 1, 0);
        tick();
        set_dec(1, 2, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        settle();
        checks++; if (stall_fd !== 1'b1) begin errors++; $display("FAIL rm_stall_pre got=%b exp=1", stall_fd); end
        tick();
        rst = 1'b0;
        settle();
        checks++; if (stall_fd !== 1'b0 || flush_fd !== 1'b0 || {ex_valid, mem_valid, wb_valid} !== 3'b000) begin errors++; $display("FAIL rm_stall_post stall=%b flush=%b valids=%b exp=0,0,000", stall_fd, flush_fd, {ex_valid, mem_valid, wb_valid}); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_dec($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            id_rsrc = W'($urandom); id_rdst = W'($urandom); ex_alu_out = W'($urandom);
            mem_rd = W'($urandom); wb_wd = W'($urandom);
            settle();
            checks++; if (opa !== e_opa) begin errors++; $display("FAIL rnd_opa cyc=%0d got=%h exp=%h", c, opa, e_opa); end
            checks++; if (opb !== e_opb) begin errors++; $display("FAIL rnd_opb cyc=%0d got=%h exp=%h", c, opb, e_opb); end
            checks++; if (fwd_sel_a !== 2'(e_sel_a)) begin errors++; $display("FAIL rnd_sel_a cyc=%0d got=%0d exp=%0d", c, fwd_sel_a, e_sel_a); end
            checks++; if (fwd_sel_b !== 2'(e_sel_b)) begin errors++; $display("FAIL rnd_sel_b cyc=%0d got=%0d exp=%0d", c, fwd_sel_b, e_sel_b); end
            checks++; if (stall_fd !== e_stall || bubble_de !== e_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b%b exp=%b", c, stall_fd, bubble_de, e_stall); end
            checks++; if (flush_fd !== e_flush) begin errors++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", c, flush_fd, e_flush); end
            checks++; if ({ex_valid, mem_valid, wb_valid} !== {stg[0].v, stg[1].v, stg[2].v}) begin errors++; $display("FAIL rnd_valids cyc=%0d got=%b exp=%b", c, {ex_valid, mem_valid, wb_valid}, {stg[0].v, stg[1].v, stg[2].v}); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        id_rsrc = '0; id_rdst = '0; ex_alu_out = '0; mem_rd = '0; wb_wd = '0;
        for (int s = 0; s < 3; s++) stg[s] = '{v: 1'b0, rw: 1'b0, ld: 1'b0, dst: 0};
        flush_left = 0;
        prev_alu   = '0;
        @(negedge clk);
        test_reset();
        test_ex_forward();
        test_load_use();
        test_priority();
        test_flush();
        test_redirect_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
